// File: rtl/pwm_ramp_controller.sv
// PWM duty ramp controller: a free-running period counter plus an IDLE/RAMP FSM
// that walks duty_cycle toward a requested target one STEP every PERIODS_PER_STEP periods.
module pwm_ramp_controller #(
  parameter int MAX_COUNT        = 255,
  parameter int STEP             = 1,
  parameter int PERIODS_PER_STEP = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [31:0] req_duty,
  output logic        req_ready,
  input  logic        abort,
  output logic [31:0] duty_cycle,
  output logic        period_start,
  output logic        busy,
  output logic        done
);

  localparam int CNT_W  = (MAX_COUNT < 1) ? 1 : $clog2(MAX_COUNT + 1);
  localparam int WRAP_W = (PERIODS_PER_STEP < 2) ? 1 : $clog2(PERIODS_PER_STEP + 1);

  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(MAX_COUNT);
  localparam logic [WRAP_W-1:0] WRAP_LAST = WRAP_W'(PERIODS_PER_STEP - 1);
  localparam logic [31:0]       DUTY_MAX  = 32'(MAX_COUNT + 1);
  localparam logic [32:0]       STEP_EXT  = 33'(STEP);

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [WRAP_W-1:0]  wraps_q, wraps_d;
  logic [31:0]        duty_q, duty_d;
  logic [31:0]        target_q, target_d;
  logic               done_q, done_d;
  logic [31:0]        req_clamped;
  logic               accept;
  logic               wrap;

  function automatic logic [31:0] clamp_target(input logic [31:0] req);
    logic [31:0] res;
    res = (req > DUTY_MAX) ? DUTY_MAX : req;
    return res;
  endfunction

  // One ramp step in 33-bit unsigned arithmetic, saturating exactly at the target.
  function automatic logic [31:0] step_toward(input logic [31:0] cur, input logic [31:0] tgt);
    logic [32:0] sum;
    logic [32:0] diff;
    logic [31:0] res;
    sum  = {1'b0, cur} + STEP_EXT;
    diff = {1'b0, cur} - {1'b0, tgt};
    if (cur < tgt) begin
      res = (sum >= {1'b0, tgt}) ? tgt : sum[31:0];
    end else begin
      res = (diff <= STEP_EXT) ? tgt : cur - STEP_EXT[31:0];
    end
    return res;
  endfunction

  assign req_clamped  = clamp_target(req_duty);
  assign req_ready    = (state_q == IDLE) && !abort && !reset;
  assign accept       = req_valid && req_ready;
  assign wrap         = (cnt_q == CNT_MAX);
  assign period_start = (cnt_q == '0) && !reset;
  assign duty_cycle   = duty_q;
  assign busy         = (state_q == RAMP);
  assign done         = done_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (wrap) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      wraps_q  <= '0;
      duty_q   <= '0;
      target_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wraps_q  <= wraps_d;
      duty_q   <= duty_d;
      target_q <= target_d;
      done_q   <= done_d;
    end
  end

  // Duty only moves on a wrap clock, so each new value covers one whole period.
  always_comb begin
    state_d  = state_q;
    wraps_d  = wraps_q;
    duty_d   = duty_q;
    target_d = target_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          target_d = req_clamped;
          wraps_d  = '0;
          if (req_clamped == duty_q) begin
            done_d = 1'b1;
          end else begin
            state_d = RAMP;
          end
        end
      end
      RAMP: begin
        if (abort) begin
          state_d = IDLE;
          wraps_d = '0;
        end else if (wrap) begin
          if (wraps_q == WRAP_LAST) begin
            wraps_d = '0;
            duty_d  = step_toward(duty_q, target_q);
            if (duty_d == target_q) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            wraps_d = wraps_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pwm_ramp_controller.sv
// Directed bench for pwm_ramp_controller with MAX_COUNT=255, STEP=16, PERIODS_PER_STEP=4.
module tb_pwm_ramp_controller;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic [31:0] req_duty;
  logic        req_ready;
  logic        abort;
  logic [31:0] duty_cycle;
  logic        period_start;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  pwm_ramp_controller #(
    .MAX_COUNT(255),
    .STEP(16),
    .PERIODS_PER_STEP(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .req_valid(req_valid),
    .req_duty(req_duty),
    .req_ready(req_ready),
    .abort(abort),
    .duty_cycle(duty_cycle),
    .period_start(period_start),
    .busy(busy),
    .done(done)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Offer a request at a negedge; it is accepted on the following posedge.
  task automatic request(input string tag, input logic [31:0] d);
    chk({tag, "_ready"}, req_ready, 1);
    req_valid = 1'b1;
    req_duty  = d;
    @(negedge clock);
    req_valid = 1'b0;
  endtask

  // Wait for duty_cycle to change; gap is the expected negedge count (0 = unchecked).
  task automatic wait_step(input string tag, input logic [31:0] exp, input int gap);
    logic [31:0] prev;
    int n;
    prev = duty_cycle;
    n = 0;
    while (duty_cycle == prev && n < 3000) begin
      @(negedge clock);
      n++;
    end
    chk(tag, duty_cycle, exp);
    chk({tag, "_ps"}, period_start, 1);
    if (gap != 0) chk({tag, "_gap"}, n, gap);
  endtask

  task automatic period_gap(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!period_start && n < 600);
    chk(tag, n, 256);
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_duty  = '0;
    abort     = 1'b0;
    #2;
    chk("rst_duty", duty_cycle, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", req_ready, 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rel_ready", req_ready, 1);
    chk("rel_ps", period_start, 1);
    period_gap("rel_gap");

    // Ramp up 0 -> 64, with an ignored request offered while busy.
    request("up", 64);
    chk("up_busy", busy, 1);
    req_valid = 1'b1;
    req_duty  = 200;
    #1;
    chk("up_busy_ready", req_ready, 0);
    repeat (3) @(negedge clock);
    req_valid = 1'b0;
    req_duty  = 0;
    wait_step("up16", 16, 0);
    chk("up16_busy", busy, 1);
    wait_step("up32", 32, 1024);
    wait_step("up48", 48, 1024);
    wait_step("up64", 64, 1024);
    chk("up_end_busy", busy, 0);
    chk("up_end_done", done, 1);
    @(negedge clock);
    chk("up_done_pulse", done, 0);
    chk("up_hold", duty_cycle, 64);

    // Ramp down 64 -> 10.
    request("dn", 10);
    wait_step("dn48", 48, 0);
    wait_step("dn32", 32, 1024);
    wait_step("dn16", 16, 1024);
    wait_step("dn10", 10, 1024);
    chk("dn_done", done, 1);
    chk("dn_busy", busy, 0);
    @(negedge clock);

    // Request equal to present duty.
    request("eq", 10);
    chk("eq_done", done, 1);
    chk("eq_busy", busy, 0);
    chk("eq_duty", duty_cycle, 10);
    @(negedge clock);
    chk("eq_done_pulse", done, 0);
    chk("eq_busy2", busy, 0);

    // Clamp 300 -> 256 from 10.
    request("clamp", 300);
    for (int k = 1; k <= 15; k++) begin
      wait_step("clamp_step", 32'(10 + 16 * k), (k == 1) ? 0 : 1024);
    end
    wait_step("clamp_sat", 256, 1024);
    chk("clamp_done", done, 1);
    repeat (2000) @(negedge clock);
    chk("clamp_hold", duty_cycle, 256);

    // Asynchronous reset between edges during a ramp.
    request("rr", 0);
    wait_step("rr240", 240, 0);
    repeat (100) @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_duty", duty_cycle, 0);
    chk("ar_busy", busy, 0);
    chk("ar_done", done, 0);
    chk("ar_ready", req_ready, 0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("ar_rel_ready", req_ready, 1);
    chk("ar_rel_ps", period_start, 1);
    chk("ar_rel_duty", duty_cycle, 0);
    period_gap("ar_gap1");
    period_gap("ar_gap2");
    chk("ar_no_done", done, 0);

    // Abort on the clock of a scheduled step at duty 32.
    request("ab", 64);
    wait_step("ab16", 16, 0);
    wait_step("ab32", 32, 1024);
    repeat (1023) @(negedge clock);
    abort = 1'b1;
    #1;
    chk("ab_ready", req_ready, 0);
    chk("ab_pre_busy", busy, 1);
    @(negedge clock);
    chk("ab_duty", duty_cycle, 32);
    chk("ab_busy", busy, 0);
    chk("ab_done", done, 0);
    abort = 1'b0;
    #1;
    chk("ab_ready_after", req_ready, 1);
    @(negedge clock);
    chk("ab_done2", done, 0);
    repeat (1100) @(negedge clock);
    chk("ab_hold", duty_cycle, 32);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
